gsim_mem_arb: RTL and testbench

GSIM_MEM_ARB -- requirements
Module: gsim_mem_arb

---
 rtl/gsim_pkg.sv | 14 +
 rtl/gsim_tag_fifo.sv | 67 ++++++
 rtl/gsim_mem_arb.sv | 112 +++++++++++
 tb/tb_gsim_mem_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared types and constants for the matrix-memory read arbiter and its tag FIFO.
package gsim_pkg;

    localparam int MEM_AW          = 10;
    localparam int MEM_DW          = 256;
    localparam int OUTSTANDING_DEF = 4;
    localparam int CNT_W           = 4;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/gsim_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per read accepted by memory and not yet returned.
module gsim_tag_fifo
    import gsim_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEF
)(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  req_id_e          i_push_id,
    input  logic             i_pop,
    output req_id_e          o_pop_id,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full   = (count_q == CNT_W'(DEPTH));
    assign o_empty  = (count_q == '0);
    assign o_count  = count_q;
    assign o_pop_id = req_id_e'(mem_q[rd_ptr_q]);
    assign push_ok  = i_push && !o_full;
    assign pop_ok   = i_pop && !o_empty;

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gsim_mem_arb.sv
// Two-requester round-robin read arbiter for the matrix memory; routes in-order
// returns back to the issuing requester one cycle after the memory presents them.
module gsim_mem_arb
    import gsim_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req0_rreq,
    input  logic [MEM_AW-1:0] i_req0_addr,
    output logic              o_req0_rrdy,
    output logic [MEM_DW-1:0] o_req0_dout,
    output logic              o_req0_dout_vld,
    input  logic              i_req1_rreq,
    input  logic [MEM_AW-1:0] i_req1_addr,
    output logic              o_req1_rrdy,
    output logic [MEM_DW-1:0] o_req1_dout,
    output logic              o_req1_dout_vld,
    output logic              o_mem_rreq,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [MEM_DW-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_out_cnt,
    output logic              o_err
);

    req_id_e           last_q, last_d;
    logic              err_q, err_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic [MEM_DW-1:0] dout0_q, dout0_d, dout1_q, dout1_d;

    logic              gnt_vld;
    req_id_e           gnt_id;
    logic              accept, pop;
    logic              fifo_full, fifo_empty;
    req_id_e           pop_id;
    logic [CNT_W-1:0]  fifo_count;

    // On a tie the requester that was NOT accepted last wins; last_q only moves on accept.
    always_comb begin
        gnt_vld = i_req0_rreq || i_req1_rreq;
        gnt_id  = REQ_ID_0;
        if (i_req0_rreq && i_req1_rreq) begin
            gnt_id = (last_q == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
        end else if (i_req1_rreq) begin
            gnt_id = REQ_ID_1;
        end
    end

    // Handshake: a read transfers on a cycle where o_mem_rreq && i_mem_rrdy; the granted
    // requester sees that same condition as its rrdy, so rreq && rrdy marks its accept.
    assign o_mem_rreq  = i_reset_n && gnt_vld && !fifo_full;
    assign o_mem_addr  = !gnt_vld ? '0 : ((gnt_id == REQ_ID_1) ? i_req1_addr : i_req0_addr);
    assign accept      = o_mem_rreq && i_mem_rrdy;
    assign o_req0_rrdy = accept && (gnt_id == REQ_ID_0);
    assign o_req1_rrdy = accept && (gnt_id == REQ_ID_1);
    assign pop         = i_mem_dout_vld && !fifo_empty;

    gsim_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (accept),
        .i_push_id (gnt_id),
        .i_pop     (pop),
        .o_pop_id  (pop_id),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    always_comb begin
        last_d  = accept ? gnt_id : last_q;
        err_d   = err_q || (i_mem_dout_vld && fifo_empty);
        vld0_d  = pop && (pop_id == REQ_ID_0);
        vld1_d  = pop && (pop_id == REQ_ID_1);
        dout0_d = vld0_d ? i_mem_dout : dout0_q;
        dout1_d = vld1_d ? i_mem_dout : dout1_q;
    end

    // last_q resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            last_q  <= REQ_ID_1;
            err_q   <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            last_q  <= last_d;
            err_q   <= err_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign o_req0_dout_vld = vld0_q;
    assign o_req1_dout_vld = vld1_q;
    assign o_req0_dout     = dout0_q;
    assign o_req1_dout     = dout1_q;
    assign o_err           = err_q;
    assign o_out_cnt       = fifo_count;
    assign o_busy          = (fifo_count != '0);

endmodule

// File: tb/tb_gsim_mem_arb.sv
// Bench for gsim_mem_arb: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the arbiter's rules.
module tb_gsim_mem_arb;

    localparam int OUTSTANDING = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_rreq = 1'b0, req1_rreq = 1'b0;
    logic [9:0]   req0_addr = '0, req1_addr = '0;
    logic         req0_rrdy, req1_rrdy;
    logic [255:0] req0_dout, req1_dout;
    logic         req0_dout_vld, req1_dout_vld;
    logic         mem_rreq;
    logic [9:0]   mem_addr;
    logic         mem_rrdy = 1'b0;
    logic [255:0] mem_dout = '0;
    logic         mem_dout_vld = 1'b0;
    logic         busy;
    logic [3:0]   out_cnt;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_pend = 0;

    // reference model state
    logic [0:0]   exp_q[$];
    logic         m_last = 1'b1;
    logic         m_err = 1'b0;
    logic         m_vld [0:1] = '{1'b0, 1'b0};
    logic [255:0] m_dout [0:1] = '{256'd0, 256'd0};

    always #5 clk = ~clk;

    gsim_mem_arb #(.OUTSTANDING(OUTSTANDING)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_req0_rreq     (req0_rreq),
        .i_req0_addr     (req0_addr),
        .o_req0_rrdy     (req0_rrdy),
        .o_req0_dout     (req0_dout),
        .o_req0_dout_vld (req0_dout_vld),
        .i_req1_rreq     (req1_rreq),
        .i_req1_addr     (req1_addr),
        .o_req1_rrdy     (req1_rrdy),
        .o_req1_dout     (req1_dout),
        .o_req1_dout_vld (req1_dout_vld),
        .o_mem_rreq      (mem_rreq),
        .o_mem_addr      (mem_addr),
        .i_mem_rrdy      (mem_rrdy),
        .i_mem_dout      (mem_dout),
        .i_mem_dout_vld  (mem_dout_vld),
        .o_busy          (busy),
        .o_out_cnt       (out_cnt),
        .o_err           (err)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [9:0] a0, input logic [9:0] a1,
                         input logic mrdy, input logic dv, input logic [255:0] d);
        req0_rreq    = r0;
        req1_rreq    = r1;
        req0_addr    = a0;
        req1_addr    = a1;
        mem_rrdy     = mrdy;
        mem_dout_vld = dv;
        mem_dout     = d;
    endtask

    // Checks all outputs at the falling edge, then advances the model across the rising edge.
    task automatic run_cycle();
        logic gv, gid, full, mrq, acc;
        logic [0:0] pid;
        @(negedge clk);
        gv   = req0_rreq | req1_rreq;
        gid  = (req0_rreq && req1_rreq) ? ~m_last : req1_rreq;
        full = (exp_q.size() >= OUTSTANDING);
        mrq  = rst_n && gv && !full;
        check_eq("mem_rreq", mem_rreq, mrq);
        check_eq("mem_addr", mem_addr, gv ? (gid ? req1_addr : req0_addr) : 10'd0);
        check_eq("rrdy0", req0_rrdy, mrq && mem_rrdy && !gid);
        check_eq("rrdy1", req1_rrdy, mrq && mem_rrdy && gid);
        check_eq("out_cnt", out_cnt, exp_q.size());
        check_eq("busy", busy, exp_q.size() != 0);
        check_eq("err", err, m_err);
        check_eq("dout_vld0", req0_dout_vld, m_vld[0]);
        check_eq("dout_vld1", req1_dout_vld, m_vld[1]);
        check_eq("dout0", req0_dout, m_dout[0]);
        check_eq("dout1", req1_dout, m_dout[1]);
        acc = mrq && mem_rrdy;
        if (mem_dout_vld && mem_pend > 0) mem_pend--;
        if (acc) mem_pend++;
        if (!rst_n) begin
            exp_q.delete();
            m_last = 1'b1;
            m_err  = 1'b0;
            m_vld  = '{1'b0, 1'b0};
            m_dout = '{256'd0, 256'd0};
        end else begin
            m_vld = '{1'b0, 1'b0};
            if (mem_dout_vld) begin
                if (exp_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    pid = exp_q.pop_front();
                    m_vld[pid]  = 1'b1;
                    m_dout[pid] = mem_dout;
                end
            end
            if (acc) begin
                exp_q.push_back(gid);
                m_last = gid;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] ab_pat;
        logic [255:0] rnd;
        ab_pat = {32{8'hAB}};

        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        check_eq("reset out_cnt", out_cnt, 4'd0);
        check_eq("reset err", err, 1'b0);
        check_eq("reset dout0", req0_dout, 256'd0);
        rst_n = 1'b1;

        // single read from req0, data back three cycles after the accept
        drive(1'b1, 1'b0, 10'h011, 10'h000, 1'b1, 1'b0, '0);
        #1;
        check_eq("t028 mem_addr", mem_addr, 10'h011);
        run_cycle();
        drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, '0);
        run_cycle();
        run_cycle();
        drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, ab_pat);
        run_cycle();
        drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, '0);
        check_eq("t028 vld0", req0_dout_vld, 1'b1);
        check_eq("t028 vld1", req1_dout_vld, 1'b0);
        check_eq("t028 dout0", req0_dout, ab_pat);
        run_cycle();

        // alternation on persistent ties, starting from reset
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 10'h001, 10'h002, 1'b1, 1'b0, '0);
            #1;
            check_eq("t029 mem_addr", mem_addr, (i % 2 == 0) ? 10'h001 : 10'h002);
            run_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, {8{$urandom()}});
            run_cycle();
        end

        // fill to OUTSTANDING with the memory withholding data
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 10'(i + 16), 10'h000, 1'b1, 1'b0, '0);
            #1;
            check_eq("t030 rrdy0", req0_rrdy, i < 4);
            run_cycle();
        end
        check_eq("t030 out_cnt", out_cnt, 4'd4);

        // full plus a return in the same cycle: no accept until the next cycle
        drive(1'b0, 1'b1, 10'h000, 10'h033, 1'b1, 1'b1, {8{$urandom()}});
        #1;
        check_eq("t031 rrdy1 full", req1_rrdy, 1'b0);
        run_cycle();
        check_eq("t031 out_cnt", out_cnt, 4'd3);
        drive(1'b0, 1'b1, 10'h000, 10'h033, 1'b1, 1'b0, '0);
        #1;
        check_eq("t031 rrdy1 next", req1_rrdy, 1'b1);
        run_cycle();
        check_eq("t031 out_cnt refill", out_cnt, 4'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, {8{$urandom()}});
            run_cycle();
        end

        // spurious return with nothing outstanding
        drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, {8{$urandom()}});
        run_cycle();
        drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, '0);
        check_eq("t032 vld0", req0_dout_vld, 1'b0);
        check_eq("t032 vld1", req1_dout_vld, 1'b0);
        check_eq("t032 err", err, 1'b1);
        run_cycle();
        run_cycle();
        check_eq("t032 err sticky", err, 1'b1);

        // reset with two reads outstanding
        drive(1'b1, 1'b1, 10'h005, 10'h006, 1'b1, 1'b0, '0);
        run_cycle();
        run_cycle();
        check_eq("t033 out_cnt before", out_cnt, 4'd2);
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        check_eq("t033 out_cnt", out_cnt, 4'd0);
        check_eq("t033 busy", busy, 1'b0);
        check_eq("t033 err", err, 1'b0);
        drive(1'b1, 1'b1, 10'h007, 10'h008, 1'b1, 1'b0, '0);
        #1;
        check_eq("t033 tie addr", mem_addr, 10'h007);
        check_eq("t033 tie rrdy0", req0_rrdy, 1'b1);
        run_cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {8{$urandom()}};
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                  10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  $urandom_range(0, 3) != 0,
                  (mem_pend > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0),
                  rnd);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
